ahfp_to_int: RTL and testbench

Pipelined IEEE-754 single-precision to signed 32-bit integer converter with valid/ready flow control. Sits directly downstream of the `ahfp_floor` stage and consumes its integral-valued float result. Produces a two's-complement integer with saturation and NaN flagging for the integer datapath. Any residual fraction bits are truncated toward zero, so the block stays correct even when fed unfloored operands.

---
 rtl/ahfp_pkg.sv | 51 +++++
 rtl/ahfp_align_shift.sv | 31 +++
 rtl/ahfp_to_int.sv | 134 +++++++++++++
 tb/tb_ahfp_to_int.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
`default_nettype none
// ============================================================================
// Module : ahfp_pkg
// Brief  : Shared float-field constants, class enum and classifier.
// Rev    : 1.0
// ============================================================================
package ahfp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;
    localparam int FP_SIG_W = FP_MAN_W + 1;

    localparam logic [FP_EXP_W-1:0] EXP_MAX  = 8'd255;
    // Exponent at which |x| reaches 2^31, and at which the significand LSB has weight 1.
    localparam logic [FP_EXP_W-1:0] EXP_SAT  = 8'(FP_BIAS + 31);
    localparam logic [FP_EXP_W-1:0] EXP_UNIT = 8'(FP_BIAS + FP_MAN_W);

    localparam logic [31:0] INT_SAT_POS = 32'h7FFFFFFF;
    localparam logic [31:0] INT_SAT_NEG = 32'h80000000;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        SAT  = 2'd2,
        NAN  = 2'd3
    } ahfp_class_t;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } ahfp_fields_t;

    function automatic ahfp_class_t ahfp_classify(input ahfp_fields_t f);
        ahfp_class_t cls;
        if (f.exp == EXP_MAX && f.man != '0)
            cls = NAN;
        else if (f.exp < 8'(FP_BIAS))
            cls = ZERO;
        else if (f.exp == EXP_SAT && f.man == '0 && f.sign)
            cls = NORM;  // exactly -2^31 is representable
        else if (f.exp >= EXP_SAT)
            cls = SAT;
        else
            cls = NORM;
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahfp_align_shift.sv
`default_nettype none
// ============================================================================
// Module : ahfp_align_shift
// Brief  : 24-to-32-bit bidirectional barrel shift placing the binary point.
// Rev    : 1.0
// ============================================================================
module ahfp_align_shift
    import ahfp_pkg::*;
(
    input  logic [FP_SIG_W-1:0] sig,
    input  logic [FP_EXP_W-1:0] exp,
    output logic [31:0]         mag
);

    logic [31:0]         ext;
    logic [FP_EXP_W-1:0] lsh;
    logic [FP_EXP_W-1:0] rsh;

    // Right shifts drop fraction bits, giving truncation toward zero.
    always_comb begin
        ext = {{(32-FP_SIG_W){1'b0}}, sig};
        lsh = exp - EXP_UNIT;
        rsh = EXP_UNIT - exp;
        if (exp >= EXP_UNIT)
            mag = ext << lsh;
        else
            mag = ext >> rsh;
    end

endmodule
`default_nettype wire

// File: rtl/ahfp_to_int.sv
`default_nettype none
// ============================================================================
// Module : ahfp_to_int
// Brief  : 3-stage float32 -> int32 converter, saturating, valid/ready.
// Rev    : 1.0
// ============================================================================
module ahfp_to_int
    import ahfp_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_nan
);

    generate
        if (OUT_W != 32) begin : g_out_w_check
            $error("ahfp_to_int: only OUT_W = 32 is supported");
        end
    endgenerate

    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    logic accept;

    ahfp_fields_t in_f;

    logic                s1_sign;
    logic [FP_EXP_W-1:0] s1_exp;
    logic [FP_SIG_W-1:0] s1_sig;
    ahfp_class_t         s1_cls;

    logic                s2_sign;
    ahfp_class_t         s2_cls;
    logic [31:0]         s2_mag;
    logic [31:0]         shift_mag;

    logic [OUT_W-1:0]    s3_data_d;
    logic                s3_ovf_d;
    logic                s3_nan_d;

    // A stage moves on when its successor is empty or moving itself.
    assign adv3      = v3 & out_ready;
    assign adv2      = v2 & (~v3 | adv3);
    assign adv1      = v1 & (~v2 | adv2);
    assign in_ready  = ~v1 | adv1;
    assign accept    = in_valid & in_ready;
    assign out_valid = v3;
    assign in_f      = ahfp_fields_t'(in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (in_ready)
                v1 <= in_valid;
            if (~v2 | adv2)
                v2 <= v1;
            if (~v3 | adv3)
                v3 <= v2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_sig  <= '0;
            s1_cls  <= ZERO;
        end else if (accept) begin
            s1_sign <= in_f.sign;
            s1_exp  <= in_f.exp;
            s1_sig  <= {1'b1, in_f.man};
            s1_cls  <= ahfp_classify(in_f);
        end
    end

    ahfp_align_shift u_align (
        .sig (s1_sig),
        .exp (s1_exp),
        .mag (shift_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign <= 1'b0;
            s2_cls  <= ZERO;
            s2_mag  <= '0;
        end else if (adv1) begin
            s2_sign <= s1_sign;
            s2_cls  <= s1_cls;
            s2_mag  <= (s1_cls == NORM) ? shift_mag : '0;
        end
    end

    always_comb begin
        s3_data_d = '0;
        s3_ovf_d  = 1'b0;
        s3_nan_d  = 1'b0;
        case (s2_cls)
            NORM: s3_data_d = s2_sign ? (~s2_mag + 32'd1) : s2_mag;
            SAT: begin
                s3_data_d = s2_sign ? INT_SAT_NEG : INT_SAT_POS;
                s3_ovf_d  = 1'b1;
            end
            NAN:     s3_nan_d = 1'b1;
            default: s3_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ovf  <= 1'b0;
            out_nan  <= 1'b0;
        end else if (adv2) begin
            out_data <= s3_data_d;
            out_ovf  <= s3_ovf_d;
            out_nan  <= s3_nan_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahfp_to_int.sv
`default_nettype none
// ============================================================================
// Module : tb_ahfp_to_int
// Brief  : Directed and throttled-random self-checking bench for ahfp_to_int.
// Rev    : 1.0
// ============================================================================
module tb_ahfp_to_int;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_nan;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] f;
        logic [31:0] d;
        logic        o;
        logic        n;
    } vec_t;

    always #5 clk = ~clk;

    ahfp_to_int #(.OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_nan   (out_nan)
    );

    // Independent reference: 64-bit magnitude with range comparison.
    function automatic logic [33:0] ref_model(input logic [31:0] f);
        logic            s;
        int              e;
        longint unsigned mag;
        logic [31:0]     d;
        s = f[31];
        e = int'(f[30:23]);
        if (e == 255 && f[22:0] != 23'd0) return {2'b10, 32'd0};
        if (e < 127) return 34'd0;
        if (e >= 190) return s ? {2'b01, 32'h80000000} : {2'b01, 32'h7FFFFFFF};
        mag = {40'd0, 1'b1, f[22:0]};
        if (e >= 150) mag = mag << (e - 150);
        else          mag = mag >> (150 - e);
        if (!s && mag > 64'h7FFFFFFF) return {2'b01, 32'h7FFFFFFF};
        if (s && mag > 64'h80000000)  return {2'b01, 32'h80000000};
        d = mag[31:0];
        if (s) d = -d;
        return {2'b00, d};
    endfunction

    function automatic logic [31:0] gen_float();
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        int          sel;
        s   = 1'($urandom_range(0, 1));
        m   = 23'($urandom);
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       e = 8'($urandom_range(0, 126));
            1:       e = 8'd255;
            2:       e = 8'($urandom_range(158, 254));
            default: e = 8'($urandom_range(127, 158));
        endcase
        // Some operands are floored so integral values dominate.
        if (sel >= 3 && sel <= 5 && e < 8'd150)
            m = m & ~((23'd1 << (150 - int'(e))) - 23'd1);
        return {s, e, m};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        n_tests++;
        if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
        n_tests++;
        if (out_nan !== 1'b0) begin n_fail++; $display("FAIL reset_out_nan: got %b expected 0", out_nan); end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] vin [2];
        logic [31:0] vexp [2];
        vin  = '{32'h40400000, 32'hC2F60000};
        vexp = '{32'h00000003, 32'hFFFFFF85};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 2);
            if (c < 2) in_data = vin[c];
            #1;
            if (c == 2 || c == 5) begin
                n_tests++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle[%0d]: got out_valid %b expected 0", c, out_valid); end
            end
            if (c == 3 || c == 4) begin
                n_tests++;
                if ({out_valid, out_data} !== {1'b1, vexp[c-3]}) begin
                    n_fail++;
                    $display("FAIL basic[%0d]: got valid %b data %h expected valid 1 data %h", c - 3, out_valid, out_data, vexp[c-3]);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_boundaries();
        vec_t t [7];
        t = '{
            '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0},
            '{32'hCF000000, 32'h80000000, 1'b0, 1'b0},
            '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0},
            '{32'hFF800000, 32'h80000000, 1'b1, 1'b0},
            '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0},
            '{32'hCF000001, 32'h80000000, 1'b1, 1'b0},
            '{32'h4B7FFFFF, 32'h00FFFFFF, 1'b0, 1'b0}
        };
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 7);
            if (c < 7) in_data = t[c].f;
            #1;
            if (c >= 3) begin
                n_tests++;
                if ({out_valid, out_nan, out_ovf, out_data} !== {1'b1, t[c-3].n, t[c-3].o, t[c-3].d}) begin
                    n_fail++;
                    $display("FAIL boundary[%h]: got v%b n%b o%b %h expected v1 n%b o%b %h", t[c-3].f,
                             out_valid, out_nan, out_ovf, out_data, t[c-3].n, t[c-3].o, t[c-3].d);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_specials();
        vec_t t [10];
        t = '{
            '{32'h7FC00000, 32'h00000000, 1'b0, 1'b1},
            '{32'h3F000000, 32'h00000000, 1'b0, 1'b0},
            '{32'h80000000, 32'h00000000, 1'b0, 1'b0},
            '{32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{32'h00000001, 32'h00000000, 1'b0, 1'b0},
            '{32'hFF800001, 32'h00000000, 1'b0, 1'b1},
            '{32'h3F800000, 32'h00000001, 1'b0, 1'b0},
            '{32'hBF800000, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{32'h40490FDB, 32'h00000003, 1'b0, 1'b0},
            '{32'h7F7FFFFF, 32'h7FFFFFFF, 1'b1, 1'b0}
        };
        out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            in_valid = (c < 10);
            if (c < 10) in_data = t[c].f;
            #1;
            if (c >= 3) begin
                n_tests++;
                if ({out_valid, out_nan, out_ovf, out_data} !== {1'b1, t[c-3].n, t[c-3].o, t[c-3].d}) begin
                    n_fail++;
                    $display("FAIL special[%h]: got v%b n%b o%b %h expected v1 n%b o%b %h", t[c-3].f,
                             out_valid, out_nan, out_ovf, out_data, t[c-3].n, t[c-3].o, t[c-3].d);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] fin [6];
        int sent = 0;
        int got  = 0;
        fin = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        for (int c = 0; c < 40 && got < 6; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 6);
            if (sent < 6) in_data = fin[sent];
            #1;
            if (c == 3 || c == 4) begin
                n_tests++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
                n_tests++;
                if ({out_valid, out_data} !== {1'b1, 32'd1}) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d]: got valid %b data %h expected valid 1 data 00000001", c, out_valid, out_data);
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                n_tests++;
                if (out_data !== 32'(got + 1)) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got %h expected %h", got, out_data, 32'(got + 1));
                end
                got++;
            end
            @(negedge clk);
        end
        n_tests++;
        if (got != 6 || sent != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d out / %0d in expected 6 / 6", got, sent);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h40000000 + (32'(c) << 20);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_loaded: got out_valid %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_flush: got out_valid %b expected 0", out_valid); end
        n_tests++;
        if (out_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00000000", out_data); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid) stale++;
            @(negedge clk);
        end
        n_tests++;
        if (stale != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d outputs expected 0", stale); end
    endtask

    task automatic test_random(input int n);
        logic [33:0] q [$];
        logic [33:0] want;
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        logic holding = 1'b0;
        while (got < n && cyc < 60000) begin
            if (!holding) begin
                in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
                if (in_valid) in_data = gen_float();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                q.push_back(ref_model(in_data));
                sent++;
                holding = 1'b0;
            end else begin
                holding = in_valid;
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_extra: got %h with empty scoreboard expected no output", out_data);
                end else begin
                    want = q.pop_front();
                    if ({out_nan, out_ovf, out_data} !== want) begin
                        n_fail++;
                        $display("FAIL random[%0d]: got n%b o%b %h expected n%b o%b %h", got,
                                 out_nan, out_ovf, out_data, want[33], want[32], want[31:0]);
                    end
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (got != n) begin n_fail++; $display("FAIL random_timeout: got %0d outputs expected %0d", got, n); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundaries();
        test_specials();
        test_backpressure();
        test_reset_mid();
        test_random(10000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
